// File: rtl/lab1_imul_mul_client.sv
// Batch request initiator for the integer multiplier: issues (a0+i, b0+i) for i < n,
// keeps at most p_max_inflight requests outstanding, and returns the 32-bit sum of products.
module lab1_imul_mul_client #(
  parameter int p_max_inflight = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_val,
  output logic        cmd_rdy,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic [7:0]  cmd_n,
  output logic        mul_req_val,
  input  logic        mul_req_rdy,
  output logic [63:0] mul_req_msg,
  input  logic        mul_resp_val,
  output logic        mul_resp_rdy,
  input  logic [31:0] mul_resp_msg,
  output logic        done_val,
  input  logic        done_rdy,
  output logic [31:0] done_sum,
  output logic [7:0]  done_count
);

  localparam int IW = $clog2(p_max_inflight + 1);
  localparam logic [IW-1:0] MAX_INF = IW'(p_max_inflight);
  localparam logic [IW-1:0] INF_ONE = IW'(1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state_q, state_d;
  logic [31:0]     a0_q, a0_d, b0_q, b0_d, sum_q, sum_d;
  logic [7:0]      n_q, n_d, issued_q, issued_d, received_q, received_d;
  logic [IW-1:0]   inflight_q, inflight_d;

  logic cmd_fire, req_fire, resp_fire, done_fire;

  // Every valid/ready is forced low while reset is high, independent of state.
  assign cmd_rdy      = !reset && (state_q == IDLE);
  assign mul_req_val  = !reset && (state_q == RUN) && (issued_q < n_q) && (inflight_q < MAX_INF);
  assign mul_resp_rdy = !reset && (state_q == RUN);
  assign done_val     = !reset && (state_q == DONE);
  assign done_sum     = reset ? 32'd0 : sum_q;
  assign done_count   = reset ? 8'd0  : received_q;
  assign mul_req_msg  = {a0_q + {24'd0, issued_q}, b0_q + {24'd0, issued_q}};

  assign cmd_fire  = cmd_val && cmd_rdy;
  assign req_fire  = mul_req_val && mul_req_rdy;
  // A response with nothing outstanding is a protocol violation and is dropped.
  assign resp_fire = mul_resp_val && mul_resp_rdy && (inflight_q != '0);
  assign done_fire = done_val && done_rdy;

  always_comb begin
    state_d    = state_q;
    a0_d       = a0_q;
    b0_d       = b0_q;
    n_d        = n_q;
    issued_d   = issued_q;
    received_d = received_q;
    inflight_d = inflight_q;
    sum_d      = sum_q;
    case (state_q)
      IDLE: begin
        if (cmd_fire) begin
          a0_d       = cmd_a;
          b0_d       = cmd_b;
          n_d        = cmd_n;
          issued_d   = '0;
          received_d = '0;
          inflight_d = '0;
          sum_d      = '0;
          state_d    = (cmd_n != 8'd0) ? RUN : DONE;
        end
      end
      RUN: begin
        if (req_fire) issued_d = issued_q + 8'd1;
        if (req_fire && !resp_fire) inflight_d = inflight_q + INF_ONE;
        if (!req_fire && resp_fire) inflight_d = inflight_q - INF_ONE;
        if (resp_fire) begin
          sum_d      = sum_q + mul_resp_msg;
          received_d = received_q + 8'd1;
          if (received_d == n_q) state_d = DONE;
        end
      end
      DONE: begin
        if (done_fire) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      a0_q       <= '0;
      b0_q       <= '0;
      n_q        <= '0;
      issued_q   <= '0;
      received_q <= '0;
      inflight_q <= '0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      a0_q       <= a0_d;
      b0_q       <= b0_d;
      n_q        <= n_d;
      issued_q   <= issued_d;
      received_q <= received_d;
      inflight_q <= inflight_d;
      sum_q      <= sum_d;
    end
  end

  resp_without_request: assert property (@(posedge clk) disable iff (reset)
    (state_q == RUN && mul_resp_val) |-> (inflight_q != '0));

endmodule

// File: tb/tb_lab1_imul_mul_client.sv
// Directed bench for lab1_imul_mul_client: a queue-based multiplier model answers requests,
// a vector table drives whole batches, and hand-written sequences cover inflight limit and reset.
module tb_lab1_imul_mul_client;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_val = 1'b0;
  logic        cmd_rdy;
  logic [31:0] cmd_a = '0, cmd_b = '0;
  logic [7:0]  cmd_n = '0;
  logic        mul_req_val;
  logic        mul_req_rdy = 1'b1;
  logic [63:0] mul_req_msg;
  logic        mul_resp_val = 1'b0;
  logic        mul_resp_rdy;
  logic [31:0] mul_resp_msg = '0;
  logic        done_val;
  logic        done_rdy = 1'b1;
  logic [31:0] done_sum;
  logic [7:0]  done_count;

  lab1_imul_mul_client #(.p_max_inflight(4)) dut (
    .clk(clk), .reset(reset),
    .cmd_val(cmd_val), .cmd_rdy(cmd_rdy), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_n(cmd_n),
    .mul_req_val(mul_req_val), .mul_req_rdy(mul_req_rdy), .mul_req_msg(mul_req_msg),
    .mul_resp_val(mul_resp_val), .mul_resp_rdy(mul_resp_rdy), .mul_resp_msg(mul_resp_msg),
    .done_val(done_val), .done_rdy(done_rdy), .done_sum(done_sum), .done_count(done_count)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] mul32(input logic [31:0] x, input logic [31:0] y);
    return x * y;
  endfunction

  // Multiplier model and transfer monitor
  logic [31:0] q[$];
  int          budget = -1;
  bit          bp = 1'b0;
  int          req_count = 0, resp_count = 0, req_idx = 0;
  logic [31:0] exp_a0 = '0, exp_b0 = '0;
  bit          done_seen = 1'b0;
  logic [31:0] got_sum;
  logic [7:0]  got_cnt;
  logic        cmd_rdy_at_done;
  int          cyc = 0, first_req_cyc = 0, last_req_cyc = 0;
  bit          prev_pend = 1'b0;
  logic [63:0] prev_msg = '0;
  bit          s_req, s_resp, s_rst;
  logic [31:0] s_prod;

  always begin
    @(negedge clk);
    cyc++;
    s_rst  = reset;
    s_req  = mul_req_val && mul_req_rdy;
    s_resp = mul_resp_val && mul_resp_rdy;
    s_prod = mul32(mul_req_msg[63:32], mul_req_msg[31:0]);
    if (prev_pend && !reset) begin
      check("req_hold_val", {63'd0, mul_req_val}, 64'd1);
      check("req_hold_msg", mul_req_msg, prev_msg);
    end
    prev_pend = !reset && mul_req_val && !mul_req_rdy;
    prev_msg  = mul_req_msg;
    if (s_req) begin
      check("req_a", {32'd0, mul_req_msg[63:32]}, {32'd0, exp_a0 + 32'(req_idx)});
      check("req_b", {32'd0, mul_req_msg[31:0]},  {32'd0, exp_b0 + 32'(req_idx)});
      if (req_count == 0) first_req_cyc = cyc;
      last_req_cyc = cyc;
      req_count++;
      req_idx++;
    end
    if (s_resp) begin
      resp_count++;
      if (budget > 0) budget--;
    end
    if (done_val && done_rdy) begin
      done_seen       = 1'b1;
      got_sum         = done_sum;
      got_cnt         = done_count;
      cmd_rdy_at_done = cmd_rdy;
    end
    @(posedge clk);
    #1;
    if (s_rst) q.delete();
    else begin
      if (s_resp && q.size() != 0) void'(q.pop_front());
      if (s_req) q.push_back(s_prod);
    end
    mul_req_rdy  = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
    mul_resp_val = (q.size() != 0) && (budget != 0) && (bp ? ($urandom_range(0, 1) != 0) : 1'b1);
    mul_resp_msg = (q.size() != 0) ? q[0] : 32'd0;
    done_rdy     = bp ? ($urandom_range(0, 1) != 0) : 1'b1;
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmd_rdy"},      {63'd0, cmd_rdy},      64'd0);
    check({tag, "_mul_req_val"},  {63'd0, mul_req_val},  64'd0);
    check({tag, "_mul_resp_rdy"}, {63'd0, mul_resp_rdy}, 64'd0);
    check({tag, "_done_val"},     {63'd0, done_val},     64'd0);
    check({tag, "_done_sum"},     {32'd0, done_sum},     64'd0);
    check({tag, "_done_count"},   {56'd0, done_count},   64'd0);
  endtask

  task automatic start_batch(input logic [31:0] a, input logic [31:0] b, input logic [7:0] n);
    @(posedge clk);
    #1;
    exp_a0 = a; exp_b0 = b; req_idx = 0; req_count = 0; resp_count = 0; done_seen = 1'b0;
    cmd_a = a; cmd_b = b; cmd_n = n; cmd_val = 1'b1;
    for (int t = 0; t < 50; t++) begin
      @(negedge clk);
      #1;
      if (cmd_rdy) break;
    end
    check("cmd_accept", {63'd0, cmd_rdy}, 64'd1);
    @(posedge clk);
    #1;
    cmd_val = 1'b0;
    @(negedge clk);
    #1;
    if (n == 8'd0) check("n0_done_next_cycle", {63'd0, done_val}, 64'd1);
    else           check("first_req_next_cycle", {63'd0, mul_req_val}, 64'd1);
  endtask

  task automatic finish_batch(input logic [7:0] n, input logic [31:0] sum, input logic [7:0] cnt);
    for (int t = 0; t < 3000 && !done_seen; t++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", {63'd0, done_seen}, 64'd1);
    check("done_sum", {32'd0, got_sum}, {32'd0, sum});
    check("done_count", {56'd0, got_cnt}, {56'd0, cnt});
    check("req_count", 64'(req_count), {56'd0, n});
    check("no_cmd_bypass", {63'd0, cmd_rdy_at_done}, 64'd0);
    @(negedge clk);
    #1;
    check("cmd_rdy_after_done", {63'd0, cmd_rdy}, 64'd1);
    check("done_sum_hold", {32'd0, done_sum}, {32'd0, sum});
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  n;
    logic [31:0] sum;
    logic [7:0]  cnt;
    bit          bp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    tbl[0] = '{32'd2,          32'd3,          8'd3,   32'd38,         8'd3,   1'b0};
    tbl[1] = '{32'd7,          32'd9,          8'd0,   32'd0,          8'd0,   1'b0};
    tbl[2] = '{32'hFFFF_FFFF,  32'd1,          8'd2,   32'hFFFF_FFFF,  8'd2,   1'b0};
    tbl[3] = '{32'd1,          32'd1,          8'd5,   32'd55,         8'd5,   1'b1};
    tbl[4] = '{32'd10,         32'd0,          8'd4,   32'd74,         8'd4,   1'b0};
    tbl[5] = '{32'h0001_0000,  32'h0001_0000,  8'd2,   32'h0002_0001,  8'd2,   1'b1};
    tbl[6] = '{32'd1,          32'd1,          8'd255, 32'h0054_D580,  8'd255, 1'b0};

    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    check_reset_outputs("rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("idle_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
    check("idle_done_val", {63'd0, done_val}, 64'd0);

    for (int i = 0; i < 7; i++) begin
      bp = tbl[i].bp;
      budget = -1;
      start_batch(tbl[i].a, tbl[i].b, tbl[i].n);
      finish_batch(tbl[i].n, tbl[i].sum, tbl[i].cnt);
      if (!tbl[i].bp && tbl[i].n != 8'd0)
        check("back_to_back_reqs", 64'(last_req_cyc - first_req_cyc), 64'(int'(tbl[i].n) - 1));
    end

    // Responses withheld: issue must stop at the inflight limit
    bp = 1'b0;
    budget = 0;
    start_batch(32'd1, 32'd1, 8'd10);
    repeat (20) @(negedge clk);
    #1;
    check("inflight_cap_reqs", 64'(req_count), 64'd4);
    check("inflight_cap_val", {63'd0, mul_req_val}, 64'd0);
    budget = 1;
    repeat (10) @(negedge clk);
    #1;
    check("one_resp_one_req", 64'(req_count), 64'd5);
    check("one_resp_count", 64'(resp_count), 64'd1);
    budget = -1;
    finish_batch(8'd10, 32'd385, 8'd10);

    // Reset in the middle of a batch
    budget = 2;
    start_batch(32'd1, 32'd1, 8'd6);
    for (int t = 0; t < 100 && resp_count < 2; t++) begin
      @(negedge clk);
      #1;
    end
    check("mid_resp_count", 64'(resp_count), 64'd2);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    #1;
    check_reset_outputs("midrst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    budget = -1;
    @(negedge clk);
    #1;
    check("post_rst_cmd_rdy", {63'd0, cmd_rdy}, 64'd1);
    check("post_rst_req_val", {63'd0, mul_req_val}, 64'd0);
    check("post_rst_resp_rdy", {63'd0, mul_resp_rdy}, 64'd0);
    check("post_rst_done_val", {63'd0, done_val}, 64'd0);
    start_batch(32'd1, 32'd2, 8'd1);
    finish_batch(8'd1, 32'd2, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

endmodule
